// File: rtl/ccff_loader_pkg.sv
// Shared state encoding, CRC constants and word-count helpers for the
// configuration-chain loader.
package ccff_loader_pkg;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_WAIT_WORD,
      ST_SHIFT,
      ST_DONE
   } loader_state_t;

   localparam logic [15:0] CRC_POLY = 16'h1021;
   localparam logic [15:0] CRC_INIT = 16'hFFFF;

   // Number of host words needed to cover the whole chain.
   function automatic int num_words(input int chain_len, input int word_w);
      return (chain_len + word_w - 1) / word_w;
   endfunction

   // Bits taken from the final word; a full word when the chain is an exact multiple.
   function automatic int last_bits(input int chain_len, input int word_w);
      return ((chain_len % word_w) == 0) ? word_w : (chain_len % word_w);
   endfunction

endpackage

// File: rtl/ccff_crc16_serial.sv
// Bit-serial CRC-16/CCITT (poly 0x1021, MSB-first) used to compress the
// readback stream coming off the end of the configuration chain.
module ccff_crc16_serial
   import ccff_loader_pkg::*;
(
   input  logic        clk,
   input  logic        rst_n,
   input  logic        clear,
   input  logic        en,
   input  logic        bit_in,
   output logic [15:0] crc
);

   logic fb;

   assign fb = crc[15] ^ bit_in;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         crc <= CRC_INIT;
      end else if (clear) begin
         crc <= CRC_INIT;
      end else if (en) begin
         crc <= {crc[14:0], 1'b0} ^ (fb ? CRC_POLY : 16'h0000);
      end
   end

endmodule

// File: rtl/ccff_chain_loader.sv
// Serializes host bitstream words onto a fabric configuration chain and
// CRCs the bits returned on ccff_tail.
//
// state        | meaning
// -------------+---------------------------------------------------------
// ST_IDLE      | out of reset, waiting for start
// ST_WAIT_WORD | cfg_ready high, waiting for the next bitstream word
// ST_SHIFT     | one chain bit per cycle; prefetches on the last word bit
// ST_DONE      | whole chain shifted, done high until the next start
module ccff_chain_loader
   import ccff_loader_pkg::*;
#(
   parameter int CHAIN_LEN = 68,
   parameter int WORD_W    = 32,
   parameter int CNT_W     = $clog2(CHAIN_LEN + 1)
) (
   input  logic              prog_clk,
   input  logic              pReset,
   input  logic              start,
   input  logic [WORD_W-1:0] cfg_data,
   input  logic              cfg_valid,
   output logic              cfg_ready,
   output logic              ccff_head,
   output logic              ccff_shift_en,
   input  logic              ccff_tail,
   output logic              busy,
   output logic              done,
   output logic [15:0]       tail_crc
);

   localparam int WB_W = $clog2(WORD_W + 1);

   loader_state_t     state;
   logic [WORD_W-1:0] sreg;
   logic [WB_W-1:0]   wbits;
   logic [WB_W-1:0]   ld_bits;
   logic [CNT_W-1:0]  remaining;
   logic [CNT_W-1:0]  rem_at_load;
   logic              crc_clear;

   assign crc_clear = start && ((state == ST_IDLE) || (state == ST_DONE));

   // A prefetch in SHIFT loads after the current bit, so one fewer bit is left.
   always_comb begin
      rem_at_load = (state == ST_SHIFT) ? (remaining - CNT_W'(1)) : remaining;
      if (int'(rem_at_load) >= WORD_W) begin
         ld_bits = WB_W'(WORD_W);
      end else begin
         ld_bits = WB_W'(rem_at_load);
      end
   end

   always_ff @(posedge prog_clk or negedge pReset) begin
      if (!pReset) begin
         state         <= ST_IDLE;
         sreg          <= '0;
         wbits         <= '0;
         remaining     <= '0;
         cfg_ready     <= 1'b0;
         ccff_head     <= 1'b0;
         ccff_shift_en <= 1'b0;
         busy          <= 1'b0;
         done          <= 1'b0;
      end else begin
         unique case (state)
            ST_IDLE, ST_DONE: begin
               if (start) begin
                  state     <= ST_WAIT_WORD;
                  remaining <= CNT_W'(CHAIN_LEN);
                  done      <= 1'b0;
                  busy      <= 1'b1;
                  cfg_ready <= 1'b1;
               end
            end
            ST_WAIT_WORD: begin
               if (cfg_valid) begin
                  state         <= ST_SHIFT;
                  sreg          <= cfg_data;
                  wbits         <= ld_bits;
                  ccff_head     <= cfg_data[0];
                  ccff_shift_en <= 1'b1;
                  cfg_ready     <= 1'b0;
               end
            end
            ST_SHIFT: begin
               sreg      <= sreg >> 1;
               wbits     <= wbits - WB_W'(1);
               remaining <= remaining - CNT_W'(1);
               if (wbits == WB_W'(1)) begin
                  if (remaining == CNT_W'(1)) begin
                     state         <= ST_DONE;
                     done          <= 1'b1;
                     busy          <= 1'b0;
                     ccff_shift_en <= 1'b0;
                     cfg_ready     <= 1'b0;
                  end else if (cfg_valid) begin
                     sreg      <= cfg_data;
                     wbits     <= ld_bits;
                     ccff_head <= cfg_data[0];
                     cfg_ready <= 1'b0;
                  end else begin
                     state         <= ST_WAIT_WORD;
                     ccff_shift_en <= 1'b0;
                     cfg_ready     <= 1'b1;
                  end
               end else begin
                  ccff_head <= sreg[1];
                  // Open the prefetch window on the word's last bit unless it ends the chain.
                  cfg_ready <= (wbits == WB_W'(2)) && (remaining != CNT_W'(2));
               end
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

   ccff_crc16_serial u_crc (
      .clk    (prog_clk),
      .rst_n  (pReset),
      .clear  (crc_clear),
      .en     (ccff_shift_en),
      .bit_in (ccff_tail),
      .crc    (tail_crc)
   );

endmodule

// File: tb/tb_ccff_chain_loader.sv
// Directed bench for ccff_chain_loader: 68-bit chain with a behavioural
// chain model, plus a 64-bit instance for the exact-multiple case.
module tb_ccff_chain_loader;

   localparam int CHAIN_LEN = 68;
   localparam int WORD_W    = 32;
   localparam int NW        = 3;
   localparam int LAST      = CHAIN_LEN - (NW - 1) * WORD_W;
   localparam int CHAIN_B   = 64;

   logic        prog_clk  = 1'b0;
   logic        pReset    = 1'b0;
   logic        start     = 1'b0;
   logic        cfg_valid = 1'b0;
   logic [31:0] cfg_data  = '0;
   logic        cfg_ready, ccff_head, ccff_shift_en, ccff_tail, busy, done;
   logic [15:0] tail_crc;

   logic        start_b     = 1'b0;
   logic        cfg_valid_b = 1'b0;
   logic [31:0] cfg_data_b  = '0;
   logic        tail_b      = 1'b0;
   logic        cfg_ready_b, head_b, shift_en_b, busy_b, done_b;
   logic [15:0] tail_crc_b;

   logic [CHAIN_LEN-1:0] chain = '0;

   int          checks = 0;
   int          errors = 0;
   logic [31:0] words   [NW];
   logic [31:0] words_b [3];
   bit          seq     [CHAIN_LEN];
   bit          exp_q   [$];
   logic [15:0] crc_zero, crc_seq;

   always #5 prog_clk = ~prog_clk;

   // Behavioural chain: entry at bit 0, tail at the top bit.
   assign ccff_tail = chain[CHAIN_LEN-1];
   always @(posedge prog_clk) if (ccff_shift_en) chain <= {chain[CHAIN_LEN-2:0], ccff_head};

   ccff_chain_loader #(.CHAIN_LEN(CHAIN_LEN), .WORD_W(WORD_W)) dut (
      .prog_clk(prog_clk), .pReset(pReset), .start(start), .cfg_data(cfg_data),
      .cfg_valid(cfg_valid), .cfg_ready(cfg_ready), .ccff_head(ccff_head),
      .ccff_shift_en(ccff_shift_en), .ccff_tail(ccff_tail), .busy(busy),
      .done(done), .tail_crc(tail_crc)
   );

   ccff_chain_loader #(.CHAIN_LEN(CHAIN_B), .WORD_W(WORD_W)) dut_b (
      .prog_clk(prog_clk), .pReset(pReset), .start(start_b), .cfg_data(cfg_data_b),
      .cfg_valid(cfg_valid_b), .cfg_ready(cfg_ready_b), .ccff_head(head_b),
      .ccff_shift_en(shift_en_b), .ccff_tail(tail_b), .busy(busy_b),
      .done(done_b), .tail_crc(tail_crc_b)
   );

   function automatic logic [15:0] crc_step(input logic [15:0] c, input logic b);
      logic fb;
      fb = c[15] ^ b;
      return {c[14:0], 1'b0} ^ (fb ? 16'h1021 : 16'h0000);
   endfunction

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic check_reset_vals(input string tag);
      check({tag, " cfg_ready"}, 32'(cfg_ready), 32'd0);
      check({tag, " ccff_head"}, 32'(ccff_head), 32'd0);
      check({tag, " shift_en"}, 32'(ccff_shift_en), 32'd0);
      check({tag, " busy"}, 32'(busy), 32'd0);
      check({tag, " done"}, 32'(done), 32'd0);
      check({tag, " tail_crc"}, 32'(tail_crc), 32'h0000FFFF);
   endtask

   // Runs one full load from a negedge; optional host stall, start pokes, or abort.
   task automatic run_load(input string tag, input int stall_n, input bit poke_start,
                           input int abort_at);
      int          idx = 0;
      int          stalls = stall_n;
      int          shifts = 0;
      int          cyc = 0;
      int          first_c = -1;
      int          last_c = -1;
      int          done_c = -1;
      int          done_rises = 0;
      bit          prev_done = 1'b0;
      bit          poked_shift = 1'b0;
      bit          poked_wait = 1'b0;
      bit          exp_b;
      logic [15:0] crc_exp = 16'hFFFF;
      exp_q.delete();
      for (int i = 0; i < CHAIN_LEN; i++) exp_q.push_back(seq[i]);
      for (int i = CHAIN_LEN - 1; i >= 0; i--) crc_exp = crc_step(crc_exp, chain[i]);
      start = 1'b1;
      @(negedge prog_clk);
      start = 1'b0;
      while (cyc < 400) begin
         if (ccff_shift_en) begin
            shifts++;
            if (first_c < 0) first_c = cyc;
            last_c = cyc;
            if (exp_q.size() == 0) begin
               check({tag, " extra shift"}, shifts, CHAIN_LEN);
            end else begin
               exp_b = exp_q.pop_front();
               check({tag, " head"}, 32'(ccff_head), 32'(exp_b));
            end
         end
         if (done && !prev_done) begin
            done_rises++;
            if (done_c < 0) done_c = cyc;
         end
         prev_done = done;
         if (abort_at > 0 && shifts == abort_at) begin
            pReset = 1'b0;
            #1;
            check_reset_vals({tag, " async"});
            cfg_valid = 1'b0;
            @(negedge prog_clk);
            pReset = 1'b1;
            @(negedge prog_clk);
            return;
         end
         if (done_c >= 0 && cyc >= done_c + 3) break;
         start = 1'b0;
         if (poke_start && !poked_shift && ccff_shift_en && shifts == 10) begin
            start = 1'b1;
            poked_shift = 1'b1;
         end
         if (poke_start && !poked_wait && !ccff_shift_en && cfg_ready && busy) begin
            start = 1'b1;
            poked_wait = 1'b1;
         end
         if (idx == 1 && stalls > 0 && cfg_ready) begin
            cfg_valid = 1'b0;
            stalls--;
         end else begin
            cfg_valid = (idx < NW);
         end
         cfg_data = (idx < NW) ? words[idx] : 32'h0;
         if (cfg_valid && cfg_ready) idx++;
         @(negedge prog_clk);
         cyc++;
      end
      start = 1'b0;
      cfg_valid = 1'b0;
      check({tag, " shifts"}, shifts, CHAIN_LEN);
      check({tag, " bubbles"}, (last_c - first_c + 1) - shifts, stall_n);
      check({tag, " done timing"}, done_c, last_c + 1);
      check({tag, " done rises"}, done_rises, 1);
      check({tag, " words"}, idx, NW);
      check({tag, " leftover"}, exp_q.size(), 0);
      check({tag, " crc"}, 32'(tail_crc), 32'(crc_exp));
      check({tag, " busy end"}, 32'(busy), 32'd0);
      check({tag, " ready end"}, 32'(cfg_ready), 32'd0);
      check({tag, " done end"}, 32'(done), 32'd1);
   endtask

   task automatic run_b();
      int          idx = 0;
      int          shifts = 0;
      int          cyc = 0;
      int          done_c = -1;
      bit          exp_b;
      bit          q_b [$];
      logic [15:0] crc_exp = 16'hFFFF;
      for (int w = 0; w < 2; w++)
         for (int b = 0; b < WORD_W; b++) q_b.push_back(words_b[w][b]);
      for (int i = 0; i < CHAIN_B; i++) crc_exp = crc_step(crc_exp, 1'b0);
      start_b = 1'b1;
      @(negedge prog_clk);
      start_b = 1'b0;
      while (cyc < 300) begin
         if (shift_en_b) begin
            shifts++;
            if (q_b.size() == 0) begin
               check("b extra shift", shifts, CHAIN_B);
            end else begin
               exp_b = q_b.pop_front();
               check("b head", 32'(head_b), 32'(exp_b));
            end
         end
         if (done_b && done_c < 0) done_c = cyc;
         if (done_c >= 0 && cyc >= done_c + 3) break;
         cfg_valid_b = (idx < 3);
         cfg_data_b  = (idx < 3) ? words_b[idx] : 32'h0;
         if (cfg_valid_b && cfg_ready_b) idx++;
         @(negedge prog_clk);
         cyc++;
      end
      cfg_valid_b = 1'b0;
      check("b shifts", shifts, CHAIN_B);
      check("b words", idx, 2);
      check("b done", 32'(done_b), 32'd1);
      check("b crc", 32'(tail_crc_b), 32'(crc_exp));
   endtask

   initial begin
      int k;
      words[0]   = 32'hA5A5A5A5;
      words[1]   = 32'h0F0F0F0F;
      words[2]   = 32'h0000000C;
      words_b[0] = 32'hA5A5A5A5;
      words_b[1] = 32'h0F0F0F0F;
      words_b[2] = 32'hFFFFFFFF;
      k = 0;
      for (int w = 0; w < NW; w++)
         for (int b = 0; b < ((w == NW - 1) ? LAST : WORD_W); b++) begin
            seq[k] = words[w][b];
            k++;
         end
      crc_zero = 16'hFFFF;
      crc_seq  = 16'hFFFF;
      for (int i = 0; i < CHAIN_LEN; i++) begin
         crc_zero = crc_step(crc_zero, 1'b0);
         crc_seq  = crc_step(crc_seq, seq[i]);
      end

      pReset = 1'b0;
      repeat (3) @(negedge prog_clk);
      check_reset_vals("reset");
      check("reset b done", 32'(done_b), 32'd0);
      pReset = 1'b1;
      @(negedge prog_clk);

      run_load("pass1", 0, 1'b0, 0);
      check("pass1 crc of zeros", 32'(tail_crc), 32'(crc_zero));
      run_load("pass2 stall", 5, 1'b0, 0);
      check("pass2 crc of stream", 32'(tail_crc), 32'(crc_seq));
      run_load("start poke", 5, 1'b1, 0);
      check("poke crc of stream", 32'(tail_crc), 32'(crc_seq));
      run_load("abort", 0, 1'b0, 40);
      run_load("reload", 0, 1'b0, 0);
      run_b();

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
